// File: rtl/rv32_pkg.sv
// Shared RV32 constants: data width, register address width, ALU opcodes.
// Contents: XLEN, REG_ADDR_W, ALU_ADD, ALU_SUB.
// Purely declarative; no logic, no latency, no flow control.
package rv32_pkg;
   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam logic ALU_ADD  = 1'b0;
   localparam logic ALU_SUB  = 1'b1;
endpackage

// File: rtl/operand_fetch_if.sv
// Handshake and data bus between decode/write-back and the operand-fetch stage.
// Ports: decode side (in_valid/in_ready, rs1, rs2, rd, alu_op), write-back (wb_en/wb_addr/wb_data),
//        flush, and ALU side (out_valid/out_ready, data_r1, data_r2, ALUControl, out_rd).
interface operand_fetch_if #(
   parameter int XLEN = 32
);
   import rv32_pkg::*;

   logic                  in_valid;
   logic                  in_ready;
   logic [REG_ADDR_W-1:0] rs1;
   logic [REG_ADDR_W-1:0] rs2;
   logic [REG_ADDR_W-1:0] rd;
   logic                  alu_op;
   logic                  wb_en;
   logic [REG_ADDR_W-1:0] wb_addr;
   logic [XLEN-1:0]       wb_data;
   logic                  flush;
   logic                  out_valid;
   logic                  out_ready;
   logic [XLEN-1:0]       data_r1;
   logic [XLEN-1:0]       data_r2;
   logic                  ALUControl;
   logic [REG_ADDR_W-1:0] out_rd;

   // Stage view
   modport slave (
      input  in_valid, rs1, rs2, rd, alu_op, wb_en, wb_addr, wb_data, flush, out_ready,
      output in_ready, out_valid, data_r1, data_r2, ALUControl, out_rd
   );

   // Environment view (decode, write-back and ALU combined)
   modport master (
      output in_valid, rs1, rs2, rd, alu_op, wb_en, wb_addr, wb_data, flush, out_ready,
      input  in_ready, out_valid, data_r1, data_r2, ALUControl, out_rd
   );
endinterface

// File: rtl/regfile_2r1w.sv
// Register file, NREGS x XLEN, two asynchronous read ports, one synchronous write port.
// Ports: clk, rst_n, ra1/rd1, ra2/rd2 (comb read), we/wa/wd (write at rising edge).
// x0 reads as zero and ignores writes; out-of-range addresses read zero and are not written.
module regfile_2r1w #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [rv32_pkg::REG_ADDR_W-1:0]  ra1,
   output logic [XLEN-1:0]                  rd1,
   input  logic [rv32_pkg::REG_ADDR_W-1:0]  ra2,
   output logic [XLEN-1:0]                  rd2,
   input  logic                             we,
   input  logic [rv32_pkg::REG_ADDR_W-1:0]  wa,
   input  logic [XLEN-1:0]                  wd
);
   logic [XLEN-1:0] mem [NREGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            mem[i] <= '0;
         end
      end else if (we && wa != '0 && int'(wa) < NREGS) begin
         mem[wa] <= wd;
      end
   end

   // x0 is forced to zero on the read side so the storage slot never matters.
   assign rd1 = (ra1 == '0 || int'(ra1) >= NREGS) ? '0 : mem[ra1];
   assign rd2 = (ra2 == '0 || int'(ra2) >= NREGS) ? '0 : mem[ra2];
endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads rs1/rs2 from the register file and registers a bundle for the ALU.
// Ports: clk, rst_n, bus (operand_fetch_if.slave). Latency 1 cycle from accept to out_valid.
// Backpressure: in_ready = !out_valid || out_ready; bundle holds while out_ready=0; flush empties.
// Build option OPERAND_FETCH_BYPASS_EN: same-cycle write-back data forwarded into operands.
module operand_fetch #(
   parameter int XLEN  = rv32_pkg::XLEN,
   parameter int NREGS = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   operand_fetch_if.slave bus
);
   import rv32_pkg::*;

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t          state;
   logic [XLEN-1:0] rf_rd1;
   logic [XLEN-1:0] rf_rd2;
   logic [XLEN-1:0] op1;
   logic [XLEN-1:0] op2;
   logic            accept;

   regfile_2r1w #(
      .XLEN  (XLEN),
      .NREGS (NREGS)
   ) u_regfile (
      .clk   (clk),
      .rst_n (rst_n),
      .ra1   (bus.rs1),
      .rd1   (rf_rd1),
      .ra2   (bus.rs2),
      .rd2   (rf_rd2),
      .we    (bus.wb_en),
      .wa    (bus.wb_addr),
      .wd    (bus.wb_data)
   );

`ifdef OPERAND_FETCH_BYPASS_EN
   // A write landing on this same edge would otherwise be missed by the async read.
   assign op1 = (bus.wb_en && bus.wb_addr == bus.rs1 && bus.rs1 != '0) ? bus.wb_data : rf_rd1;
   assign op2 = (bus.wb_en && bus.wb_addr == bus.rs2 && bus.rs2 != '0) ? bus.wb_data : rf_rd2;
`else
   assign op1 = rf_rd1;
   assign op2 = rf_rd2;
`endif

   assign bus.out_valid = (state == FULL);
   assign bus.in_ready  = !bus.out_valid || bus.out_ready;
   assign accept        = bus.in_valid && bus.in_ready && !bus.flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= EMPTY;
         bus.data_r1    <= '0;
         bus.data_r2    <= '0;
         bus.ALUControl <= ALU_ADD;
         bus.out_rd     <= '0;
      end else if (bus.flush) begin
         state <= EMPTY;
      end else begin
         if (accept) begin
            bus.data_r1    <= op1;
            bus.data_r2    <= op2;
            bus.ALUControl <= bus.alu_op;
            bus.out_rd     <= bus.rd;
         end
         case (state)
            EMPTY:   if (accept) state <= FULL;
            FULL:    if (!accept && bus.out_ready) state <= EMPTY;
            default: state <= EMPTY;
         endcase
      end
   end
endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed vector table, mid-cycle reset sequence,
// then randomized traffic against a register-array / single-slot reference model.
// Honours OPERAND_FETCH_BYPASS_EN for the same-cycle write-back expectation.
module tb_operand_fetch;
   import rv32_pkg::*;

`ifdef OPERAND_FETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   operand_fetch_if #(.XLEN(32)) bus();

   operand_fetch #(.XLEN(32), .NREGS(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required finish before it");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Directed vectors: inputs for one cycle, expected in_ready before the edge, outputs after it.
   typedef struct {
      logic        wb_en;
      logic [4:0]  wb_addr;
      logic [31:0] wb_data;
      logic        in_valid;
      logic [4:0]  rs1, rs2, rd;
      logic        alu_op;
      logic        out_ready;
      logic        flush;
      logic        exp_in_ready;
      logic        exp_valid;
      logic [31:0] exp_r1, exp_r2;
      logic        exp_alu;
      logic [4:0]  exp_rd;
   } vec_t;

   vec_t vt [13];

   // Reference model: architectural registers plus an optional held bundle.
   logic [31:0] mrf [32];
   bit          mhave;
   logic [31:0] m1, m2;
   logic        malu;
   logic [4:0]  mrd;

   function automatic logic [31:0] model_read(input logic [4:0] a);
      logic [31:0] v;
      v = (a == 0) ? 32'h0 : mrf[a];
      if (BYP && bus.wb_en && bus.wb_addr == a && a != 0) v = bus.wb_data;
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
      mhave = 1'b0;
   endtask

   // Called at posedge+1 with inputs already driven; leaves time at next posedge+1.
   task automatic model_step();
      bit          ready, acc;
      logic [31:0] r1, r2;
      #1;
      ready = !mhave || bus.out_ready;
      chk("rand_in_ready", {31'h0, bus.in_ready}, {31'h0, ready});
      acc = bus.in_valid && ready && !bus.flush;
      r1  = model_read(bus.rs1);
      r2  = model_read(bus.rs2);
      @(posedge clk);
      if (bus.flush) mhave = 1'b0;
      else if (acc) begin
         mhave = 1'b1; m1 = r1; m2 = r2; malu = bus.alu_op; mrd = bus.rd;
      end else if (bus.out_ready) mhave = 1'b0;
      if (bus.wb_en && bus.wb_addr != 0) mrf[bus.wb_addr] = bus.wb_data;
      #1;
      chk("rand_out_valid", {31'h0, bus.out_valid}, {31'h0, mhave});
      if (mhave) begin
         chk("rand_data_r1", bus.data_r1, m1);
         chk("rand_data_r2", bus.data_r2, m2);
         chk("rand_alu",     {31'h0, bus.ALUControl}, {31'h0, malu});
         chk("rand_out_rd",  {27'h0, bus.out_rd}, {27'h0, mrd});
      end
   endtask

   task automatic drive_idle();
      bus.in_valid = 0; bus.rs1 = 0; bus.rs2 = 0; bus.rd = 0; bus.alu_op = ALU_ADD;
      bus.wb_en = 0; bus.wb_addr = 0; bus.wb_data = 0; bus.flush = 0; bus.out_ready = 1;
   endtask

   initial begin
      //            wb  addr  data          iv  rs1 rs2 rd alu ordy fl  eirdy ev  er1           er2           ealu erd
      vt[0]  = '{1, 5,  32'h0000_000A, 0,  0,  0,  0, 0,  1,   0,  1,    0,  32'h0,        32'h0,        0,  0};
      vt[1]  = '{1, 6,  32'h0000_0003, 0,  0,  0,  0, 0,  1,   0,  1,    0,  32'h0,        32'h0,        0,  0};
      vt[2]  = '{0, 0,  32'h0,         1,  5,  6,  9, 1,  0,   0,  1,    1,  32'hA,        32'h3,        1,  9};
      // Stall: later write to x5 must not refresh the held operand.
      vt[3]  = '{1, 5,  32'h0000_0055, 1,  0,  5,  3, 0,  0,   0,  0,    1,  32'hA,        32'h3,        1,  9};
      vt[4]  = '{1, 0,  32'hFFFF_FFFF, 1,  0,  5,  3, 0,  0,   0,  0,    1,  32'hA,        32'h3,        1,  9};
      vt[5]  = '{0, 0,  32'h0,         1,  0,  5,  3, 0,  0,   0,  0,    1,  32'hA,        32'h3,        1,  9};
      // Release: next bundle with no bubble; x0 still reads 0.
      vt[6]  = '{0, 0,  32'h0,         1,  0,  5,  3, 0,  1,   0,  1,    1,  32'h0,        32'h55,       0,  3};
      // Flush while FULL and stalled drops both held and incoming.
      vt[7]  = '{0, 0,  32'h0,         1,  5,  6,  4, 1,  0,   1,  0,    0,  32'h0,        32'h0,        0,  0};
      vt[8]  = '{0, 0,  32'h0,         0,  0,  0,  0, 0,  1,   0,  1,    0,  32'h0,        32'h0,        0,  0};
      // Same-cycle write-back and read of x7.
      vt[9]  = '{1, 7,  32'h0000_1234, 1,  7,  0,  7, 0,  1,   0,  1,    1,  BYP ? 32'h1234 : 32'h0, 32'h0, 0, 7};
      vt[10] = '{0, 0,  32'h0,         1,  7,  7,  1, 1,  1,   0,  1,    1,  32'h1234,     32'h1234,     1,  1};
      vt[11] = '{0, 0,  32'h0,         0,  0,  0,  0, 0,  1,   0,  1,    0,  32'h0,        32'h0,        0,  0};
      // Flush while EMPTY drops the incoming instruction.
      vt[12] = '{0, 0,  32'h0,         1,  5,  6,  2, 1,  1,   1,  1,    0,  32'h0,        32'h0,        0,  0};

      drive_idle();
      rst_n = 1'b0;
      #3;
      chk("reset_out_valid", {31'h0, bus.out_valid}, 32'h0);
      chk("reset_data_r1",   bus.data_r1, 32'h0);
      chk("reset_data_r2",   bus.data_r2, 32'h0);
      chk("reset_alu",       {31'h0, bus.ALUControl}, 32'h0);
      chk("reset_out_rd",    {27'h0, bus.out_rd}, 32'h0);
      chk("reset_in_ready",  {31'h0, bus.in_ready}, 32'h1);
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < 13; i++) begin
         bus.wb_en = vt[i].wb_en; bus.wb_addr = vt[i].wb_addr; bus.wb_data = vt[i].wb_data;
         bus.in_valid = vt[i].in_valid; bus.rs1 = vt[i].rs1; bus.rs2 = vt[i].rs2;
         bus.rd = vt[i].rd; bus.alu_op = vt[i].alu_op;
         bus.out_ready = vt[i].out_ready; bus.flush = vt[i].flush;
         #1;
         chk($sformatf("vec%0d_in_ready", i), {31'h0, bus.in_ready}, {31'h0, vt[i].exp_in_ready});
         @(posedge clk); #1;
         chk($sformatf("vec%0d_out_valid", i), {31'h0, bus.out_valid}, {31'h0, vt[i].exp_valid});
         if (vt[i].exp_valid) begin
            chk($sformatf("vec%0d_data_r1", i), bus.data_r1, vt[i].exp_r1);
            chk($sformatf("vec%0d_data_r2", i), bus.data_r2, vt[i].exp_r2);
            chk($sformatf("vec%0d_alu", i),     {31'h0, bus.ALUControl}, {31'h0, vt[i].exp_alu});
            chk($sformatf("vec%0d_out_rd", i),  {27'h0, bus.out_rd}, {27'h0, vt[i].exp_rd});
         end
      end

      // Fill the stage (x5=0x55, x6=3), then assert reset between clock edges.
      drive_idle();
      bus.in_valid = 1; bus.rs1 = 5; bus.rs2 = 6; bus.rd = 2; bus.alu_op = ALU_SUB; bus.out_ready = 0;
      @(posedge clk); #1;
      chk("pre_rst_out_valid", {31'h0, bus.out_valid}, 32'h1);
      chk("pre_rst_data_r1",   bus.data_r1, 32'h55);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", {31'h0, bus.out_valid}, 32'h0);
      chk("midrst_data_r1",   bus.data_r1, 32'h0);
      chk("midrst_data_r2",   bus.data_r2, 32'h0);
      chk("midrst_alu",       {31'h0, bus.ALUControl}, 32'h0);
      chk("midrst_out_rd",    {27'h0, bus.out_rd}, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();

      // First accept after reset: registers were cleared, stage starts EMPTY.
      bus.out_ready = 0;
      model_step();

      for (int c = 0; c < 1500; c++) begin
         bus.in_valid  = ($urandom_range(0, 9) < 7);
         bus.out_ready = ($urandom_range(0, 9) < 6);
         bus.flush     = ($urandom_range(0, 19) == 0);
         bus.rs1       = 5'($urandom_range(0, 7));
         bus.rs2       = 5'($urandom_range(0, 7));
         bus.rd        = 5'($urandom_range(0, 31));
         bus.alu_op    = 1'($urandom_range(0, 1));
         bus.wb_en     = ($urandom_range(0, 1) == 1);
         bus.wb_addr   = 5'($urandom_range(0, 7));
         bus.wb_data   = $urandom;
         model_step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter XLEN, default 32, data width of registers and operands.
REQ-002 Parameter NREGS, default 32, number of architectural registers; x0 included.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  decoded instruction fields valid.
REQ-006 in_ready  output  1  stage can accept an instruction this cycle.
REQ-007 rs1, rs2  input  5 each  source register addresses.
REQ-008 rd  input  5  destination register address, passed through.
REQ-009 alu_op  input  1  0 = add, 1 = subtract, passed through.
REQ-010 wb_en  input  1  write-back strobe.
REQ-011 wb_addr  input  5  write-back register address.
REQ-012 wb_data  input  XLEN  write-back data.
REQ-013 flush  input  1  discard held and incoming instruction.
REQ-014 out_valid  output  1  operand bundle valid toward ALU.
REQ-015 out_ready  input  1  ALU consumes bundle this cycle.
REQ-016 data_r1, data_r2  output  XLEN  registered operands to ALU.
REQ-017 ALUControl  output  1  registered alu_op.
REQ-018 out_rd  output  5  registered rd.

Function
REQ-019 Register file SHALL hold NREGS x XLEN; x0 SHALL always read 0; writes to x0 SHALL be ignored.
REQ-020 Write-back SHALL update the addressed register at the rising edge when wb_en=1, independent of pipeline handshake.
REQ-021 Two-state FSM: EMPTY (out_valid=0), FULL (out_valid=1).
REQ-022 in_ready SHALL equal !out_valid || out_ready (combinational).
REQ-023 Accept = in_valid && in_ready && !flush; on accept, output registers SHALL load operands read at rs1/rs2, alu_op, rd; latency exactly 1 cycle.
REQ-024 EMPTY->FULL on accept; FULL->EMPTY on out_ready without accept; FULL stays FULL on simultaneous consume and accept (back-to-back, no bubble).
REQ-025 While FULL and out_ready=0, all outputs SHALL hold stable; held operands SHALL NOT be refreshed by later write-backs.
REQ-026 flush SHALL force EMPTY at the next edge, overriding accept and hold; input presented with flush is dropped.
REQ-027 rs=0 SHALL yield operand 0 regardless of wb_addr=0 traffic.

Reset
REQ-028 rst_n=0 SHALL immediately clear out_valid, data_r1, data_r2, ALUControl, out_rd and all registers to 0; FSM to EMPTY.
REQ-029 Reset mid-transfer SHALL discard the held bundle; first accept after release behaves as from EMPTY.

Configuration
REQ-030 Macro OPERAND_FETCH_BYPASS_EN defined: on accept, if wb_en && wb_addr==rsN && rsN!=0, operand N SHALL take wb_data (same-cycle bypass).
REQ-031 Macro undefined: operand N SHALL take the pre-edge register value (write visible one cycle later); no bypass logic present.

Structure
REQ-032 Shared package rv32_pkg SHALL hold XLEN, REG_ADDR_W=5, ALU_ADD=1'b0, ALU_SUB=1'b1.
REQ-033 Register array SHALL be sub-module regfile_2r1w (2 async read, 1 sync write, x0 hardwired).

Verification
REQ-034 Reset, write x5=0x0000_000A, x6=0x0000_0003, issue rs1=5 rs2=6 alu_op=1 -> next cycle out_valid=1, data_r1=0xA, data_r2=0x3, ALUControl=1.
REQ-035 Write x0=0xFFFF_FFFF, issue rs1=0 -> data_r1=0.
REQ-036 Same cycle wb_en x7=0x1234 and accept rs1=7 -> data_r1=0x1234 with BYPASS_EN, old value (0) without.
REQ-037 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs unchanged; then out_ready=1 -> new bundle next cycle, no bubble.
REQ-038 FULL with flush=1 and in_valid=1 -> next cycle out_valid=0, input not captured.
REQ-039 rst_n pulled low mid-cycle while FULL -> out_valid=0 and outputs 0 without waiting for clk.
